sram_bus_arbiter: RTL and testbench
===================================

# sram_bus_arbiter

Shares one sram-like memory bus between the fetch stage (instruction read port) and the memory stage (data read/write port). It sits between the pipeline and the bus bridge and keeps one transaction outstanding at a time. Data requests have fixed priority, and a starvation counter guarantees forward progress for fetch. Fetch cancellation on pipeline flush is handled by silently draining the cancelled instruction's response.

## Interface
- STARVE_LIMIT, 4: consecutive data grants allowed while inst_req is pending before inst is forced to win; ≥1.
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- inst_req  in  1  fetch read request; held with inst_addr until inst_addr_ok
- inst_addr  in  32  fetch address
- inst_cancel  in  1  flush pulse from fetch; drops the outstanding inst transaction's handshakes
- inst_addr_ok  out  1  inst request accepted by bus
- inst_data_ok  out  1  inst read data valid
- inst_rdata  out  32  = bus_rdata
- data_req  in  1  memory-stage request; held with payload until data_addr_ok
- data_wr  in  1  1 = write
- data_wstrb  in  4  byte enables (writes)
- data_addr  in  32  data address
- data_wdata  in  32  write data
- data_addr_ok  out  1  data request accepted by bus
- data_data_ok  out  1  read data valid / write complete
- data_rdata  out  32  = bus_rdata
- bus_req  out  1  registered request to bus
- bus_wr, bus_wstrb, bus_addr, bus_wdata  out  1/4/32/32  registered payload
- bus_addr_ok  in  1  bus accepts request
- bus_data_ok  in  1  bus response valid
- bus_rdata  in  32  bus read data

## Operation
- FSM: IDLE, ADDR, DATA. Register `owner` (0 = inst, 1 = data).
- IDLE: if any request, grant, latch payload into bus_* regs, set owner, go ADDR.
  - Priority: data wins unless streak == STARVE_LIMIT and inst_req = 1, in which case inst wins.
  - Inst grant forces bus_wr = 0 and bus_wstrb = 0.
- ADDR: bus_req = 1 and payload held stable. On bus_addr_ok, pulse owner's addr_ok (combinational) and go DATA; bus_req drops next cycle.
- DATA: on bus_data_ok, pulse owner's data_ok (combinational) and go IDLE. Writes also wait for bus_data_ok.
- streak counter, width clog2(STARVE_LIMIT+1), saturating:
  - data grant with inst_req = 1: +1
  - data grant with inst_req = 0, or any inst grant: clear
- Cancel: cancel_flag set when inst_cancel = 1 while owner = inst in ADDR or DATA. It is cleared on entry to IDLE.
  - While cancel_flag or inst_cancel is asserted, inst_addr_ok and inst_data_ok are forced 0.
  - The bus transaction still completes; bus_req is never withdrawn.
  - inst_cancel in IDLE or with owner = data: no effect.
- Requester outputs are never asserted for the non-owner. inst_rdata and data_rdata are valid only with their data_ok.

## Timing
- Reset (asynchronous, immediate): state IDLE, owner 0, streak 0, cancel_flag 0, all bus_* outputs 0, all addr_ok/data_ok 0.
- Minimum latency:
  - Request seen in IDLE at cycle 0.
  - bus_req high in cycle 1.
  - bus_addr_ok in cycle 1 gives requester addr_ok in cycle 1.
  - bus_data_ok earliest in cycle 2 gives requester data_ok in cycle 2.
  - Back in IDLE at cycle 3. Throughput: 1 transaction per 3 cycles minimum.
- bus_addr_ok low: stay in ADDR indefinitely with bus_* unchanged.
- bus_data_ok outside DATA: ignored.
- Requester dropping req before addr_ok after grant: transaction still completes (protocol violation, not guarded).
- Reset mid-transaction: response is abandoned; the downstream bus shares the same reset.

## Test plan
- Single fetch: inst_req, addr 0x1c000000; bus_addr_ok in cycle 1; bus_data_ok with rdata 0x02800000 in cycle 3 -> bus_addr = 0x1c000000, bus_wr = 0, inst_addr_ok in cycle 1, inst_data_ok one cycle in cycle 3 with inst_rdata = 0x02800000, data_* outputs stay 0.
- Simultaneous requests: cycle 0 inst_req and data write (addr 0x1c008000, wdata 0xdeadbeef, wstrb 0xf) -> data granted first (bus_wr = 1, wstrb 0xf); inst granted in the IDLE cycle after data_data_ok.
- Starvation, STARVE_LIMIT = 4: inst_req and data_req both held high, bus always ready -> grant order D,D,D,D,I,D,D,D,D,I.
- Backpressure: bus_addr_ok held low 5 cycles -> bus_req and payload constant for 5 cycles; no addr_ok to either requester; accepted on cycle 6.
- Cancel: inst transaction in DATA, inst_cancel pulse, bus_data_ok 2 cycles later -> inst_data_ok stays 0, FSM returns to IDLE, next pending data request is granted normally.
- Reset in DATA: assert reset mid-cycle -> bus_req and all ok outputs go 0 without waiting for a clock edge; after release, a new inst request completes with normal latency.

Source files
------------

// File: rtl/sram_bus_arbiter.sv
// Purpose: shares one sram-like bus between fetch (read-only) and memory-stage (read/write) requesters.
// Latency: request in IDLE -> bus_req next cycle -> addr_ok same cycle as bus_addr_ok -> data_ok same cycle as bus_data_ok.
// Backpressure: one transaction outstanding; bus_req and payload held stable until bus_addr_ok.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   inst_*                fetch port (req/addr in; addr_ok/data_ok/rdata out; cancel drops handshakes)
//   data_*                data port (req/wr/wstrb/addr/wdata in; addr_ok/data_ok/rdata out)
//   bus_*                 registered request/payload out; addr_ok/data_ok/rdata in
module sram_bus_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic        inst_cancel,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;      // 0 = inst, 1 = data
  logic [SW-1:0] streak_q, streak_d;
  logic          cancel_q, cancel_d;
  logic          bus_req_q, bus_req_d;
  logic          bus_wr_q, bus_wr_d;
  logic [3:0]    bus_wstrb_q, bus_wstrb_d;
  logic [31:0]   bus_addr_q, bus_addr_d;
  logic [31:0]   bus_wdata_q, bus_wdata_d;
  logic          inst_mask;
  logic          inst_forced;

  // Response data is a straight pass-through; it is only meaningful alongside data_ok.
  assign inst_rdata = bus_rdata;
  assign data_rdata = bus_rdata;
  assign bus_req    = bus_req_q;
  assign bus_wr     = bus_wr_q;
  assign bus_wstrb  = bus_wstrb_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    streak_d     = streak_q;
    cancel_d     = cancel_q;
    bus_req_d    = bus_req_q;
    bus_wr_d     = bus_wr_q;
    bus_wstrb_d  = bus_wstrb_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    // The cancel pulse itself masks the handshakes in the cycle it arrives.
    inst_mask    = cancel_q | inst_cancel;
    // Fetch has been passed over STARVE_LIMIT times in a row: it wins this arbitration.
    inst_forced  = inst_req && (streak_q == STREAK_MAX);

    case (state_q)
      S_IDLE: begin
        if (data_req && !inst_forced) begin
          owner_d     = 1'b1;
          bus_req_d   = 1'b1;
          bus_wr_d    = data_wr;
          bus_wstrb_d = data_wstrb;
          bus_addr_d  = data_addr;
          bus_wdata_d = data_wdata;
          state_d     = S_ADDR;
          if (!inst_req)
            streak_d = '0;
          else if (streak_q != STREAK_MAX)
            streak_d = streak_q + SW'(1);
        end else if (inst_req) begin
          owner_d     = 1'b0;
          bus_req_d   = 1'b1;
          bus_wr_d    = 1'b0;
          bus_wstrb_d = 4'h0;
          bus_addr_d  = inst_addr;
          bus_wdata_d = 32'h0;
          streak_d    = '0;
          state_d     = S_ADDR;
        end
      end
      S_ADDR: begin
        if (!owner_q && inst_cancel)
          cancel_d = 1'b1;
        if (bus_addr_ok) begin
          data_addr_ok = owner_q;
          inst_addr_ok = !owner_q && !inst_mask;
          bus_req_d    = 1'b0;
          state_d      = S_DATA;
        end
      end
      S_DATA: begin
        if (!owner_q && inst_cancel)
          cancel_d = 1'b1;
        if (bus_data_ok) begin
          data_data_ok = owner_q;
          inst_data_ok = !owner_q && !inst_mask;
          cancel_d     = 1'b0;    // cleared on the way back to IDLE
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      streak_q    <= '0;
      cancel_q    <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_wr_q    <= 1'b0;
      bus_wstrb_q <= 4'h0;
      bus_addr_q  <= 32'h0;
      bus_wdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      streak_q    <= streak_d;
      cancel_q    <= cancel_d;
      bus_req_q   <= bus_req_d;
      bus_wr_q    <= bus_wr_d;
      bus_wstrb_q <= bus_wstrb_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Purpose: directed self-checking bench for sram_bus_arbiter (STARVE_LIMIT = 4).
// Latency: inputs driven 1 time unit after each rising edge, outputs checked 1 unit later.
// Backpressure: bus_addr_ok / bus_data_ok driven directly by the directed sequence.
module tb_sram_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_cancel;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        bus_req, bus_wr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] bus_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  sram_bus_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_cancel(inst_cancel),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] exp_seq;
    int         ngrant;

    reset = 1'b1;
    inst_req = 0; inst_addr = 0; inst_cancel = 0;
    data_req = 0; data_wr = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
    bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;

    // ---------------- reset state ----------------
    #2;
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_wr", bus_wr, 0);
    chk("rst_oks", {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 0);
    tick(); tick();
    reset = 1'b0;

    // ---------------- single fetch ----------------
    inst_req = 1; inst_addr = 32'h1c000000;
    #1 chk("f_c0_bus_req", bus_req, 0);
    tick();
    bus_addr_ok = 1;
    #1;
    chk("f_c1_bus_req", bus_req, 1);
    chk("f_c1_bus_addr", bus_addr, 32'h1c000000);
    chk("f_c1_bus_wr", bus_wr, 0);
    chk("f_c1_inst_addr_ok", inst_addr_ok, 1);
    chk("f_c1_data_addr_ok", data_addr_ok, 0);
    tick();
    inst_req = 0; bus_addr_ok = 0;
    #1;
    chk("f_c2_bus_req", bus_req, 0);
    chk("f_c2_inst_data_ok", inst_data_ok, 0);
    tick();
    bus_data_ok = 1; bus_rdata = 32'h02800000;
    #1;
    chk("f_c3_inst_data_ok", inst_data_ok, 1);
    chk("f_c3_inst_rdata", inst_rdata, 32'h02800000);
    chk("f_c3_data_data_ok", data_data_ok, 0);
    tick();
    bus_data_ok = 0;
    #1 chk("f_c4_inst_data_ok", inst_data_ok, 0);

    // ---------------- simultaneous requests ----------------
    inst_req = 1; inst_addr = 32'h1c000004;
    data_req = 1; data_wr = 1; data_addr = 32'h1c008000; data_wdata = 32'hdeadbeef; data_wstrb = 4'hf;
    tick();
    bus_addr_ok = 1;
    #1;
    chk("s_bus_wr", bus_wr, 1);
    chk("s_bus_wstrb", bus_wstrb, 4'hf);
    chk("s_bus_addr", bus_addr, 32'h1c008000);
    chk("s_bus_wdata", bus_wdata, 32'hdeadbeef);
    chk("s_data_addr_ok", data_addr_ok, 1);
    chk("s_inst_addr_ok", inst_addr_ok, 0);
    tick();
    data_req = 0; data_wr = 0; data_wstrb = 0; bus_addr_ok = 0; bus_data_ok = 1;
    #1;
    chk("s_data_data_ok", data_data_ok, 1);
    chk("s_inst_data_ok", inst_data_ok, 0);
    tick();
    bus_data_ok = 0;
    #1 chk("s_idle_bus_req", bus_req, 0);
    tick();
    bus_addr_ok = 1;
    #1;
    chk("s_i_bus_req", bus_req, 1);
    chk("s_i_bus_addr", bus_addr, 32'h1c000004);
    chk("s_i_bus_wr", bus_wr, 0);
    chk("s_i_bus_wstrb", bus_wstrb, 0);
    chk("s_i_inst_addr_ok", inst_addr_ok, 1);
    tick();
    inst_req = 0; bus_addr_ok = 0; bus_data_ok = 1;
    #1 chk("s_i_inst_data_ok", inst_data_ok, 1);
    tick();
    bus_data_ok = 0;

    // ---------------- starvation: D,D,D,D,I,D,D,D,D,I ----------------
    exp_seq = 10'b0111101111;   // bit i = 1 means grant i went to data
    ngrant = 0;
    inst_req = 1; inst_addr = 32'h1c000100;
    data_req = 1; data_addr = 32'h00000800;
    bus_addr_ok = 1; bus_data_ok = 1;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (inst_addr_ok || data_addr_ok) begin
        chk($sformatf("st_grant%0d", ngrant), data_addr_ok, exp_seq[ngrant]);
        chk($sformatf("st_excl%0d", ngrant), inst_addr_ok & data_addr_ok, 0);
        ngrant++;
        if (ngrant == 10) break;
      end
    end
    chk("st_grant_count", ngrant, 10);
    inst_req = 0; data_req = 0;
    tick();                       // DATA, bus_data_ok completes the last grant
    tick();
    bus_addr_ok = 0; bus_data_ok = 0;

    // ---------------- backpressure ----------------
    data_req = 1; data_addr = 32'h00001234;
    tick();
    for (int c = 1; c <= 5; c++) begin
      #1;
      chk($sformatf("bp_req_c%0d", c), bus_req, 1);
      chk($sformatf("bp_addr_c%0d", c), bus_addr, 32'h00001234);
      chk($sformatf("bp_oks_c%0d", c), {inst_addr_ok, data_addr_ok}, 0);
      tick();
    end
    bus_addr_ok = 1;
    #1;
    chk("bp_c6_data_addr_ok", data_addr_ok, 1);
    chk("bp_c6_bus_addr", bus_addr, 32'h00001234);
    tick();
    data_req = 0; bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'hcafef00d;
    #1;
    chk("bp_data_data_ok", data_data_ok, 1);
    chk("bp_data_rdata", data_rdata, 32'hcafef00d);
    tick();
    bus_data_ok = 0;

    // ---------------- cancel in DATA ----------------
    inst_req = 1; inst_addr = 32'h1c000010;
    tick();
    bus_addr_ok = 1;
    #1 chk("c_inst_addr_ok", inst_addr_ok, 1);
    tick();
    inst_req = 0; bus_addr_ok = 0;
    data_req = 1; data_addr = 32'h00002000;
    inst_cancel = 1;
    #1 chk("c_pulse_inst_data_ok", inst_data_ok, 0);
    tick();
    inst_cancel = 0;
    #1 chk("c_wait_bus_req", bus_req, 0);
    tick();
    bus_data_ok = 1;
    #1;
    chk("c_drain_inst_data_ok", inst_data_ok, 0);
    chk("c_drain_data_data_ok", data_data_ok, 0);
    tick();
    bus_data_ok = 0;
    #1 chk("c_idle_bus_req", bus_req, 0);
    tick();
    bus_addr_ok = 1;
    #1;
    chk("c_d_bus_req", bus_req, 1);
    chk("c_d_bus_addr", bus_addr, 32'h00002000);
    chk("c_d_data_addr_ok", data_addr_ok, 1);
    tick();
    data_req = 0; bus_addr_ok = 0; bus_data_ok = 1;
    #1 chk("c_d_data_data_ok", data_data_ok, 1);
    tick();
    bus_data_ok = 0;

    // ---------------- reset in DATA ----------------
    inst_req = 1; inst_addr = 32'h1c000040;
    tick();
    bus_addr_ok = 1;
    tick();
    inst_req = 0; bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h0badf00d;
    #1 chk("r_pre_inst_data_ok", inst_data_ok, 1);
    #1 reset = 1;
    #1;
    chk("r_async_inst_data_ok", inst_data_ok, 0);
    chk("r_async_bus_addr", bus_addr, 0);
    chk("r_async_bus_req", bus_req, 0);
    bus_data_ok = 0;
    tick();
    reset = 0;
    inst_req = 1; inst_addr = 32'h1c000020;
    tick();
    bus_addr_ok = 1;
    #1;
    chk("r_new_bus_addr", bus_addr, 32'h1c000020);
    chk("r_new_inst_addr_ok", inst_addr_ok, 1);
    tick();
    inst_req = 0; bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h12345678;
    #1;
    chk("r_new_inst_data_ok", inst_data_ok, 1);
    chk("r_new_inst_rdata", inst_rdata, 32'h12345678);
    tick();
    bus_data_ok = 0;
    #1 chk("r_new_idle_oks", {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
